// File: rtl/xgmii_udp_rx_filter.sv
// xgmii_udp_rx_filter
//   Parses Ethernet/IPv4/UDP frames on the 64-bit XGMII receive path and
//   qualifies each one by destination MAC, destination IP, a window of
//   NUM_PORTS consecutive UDP destination ports and a 32-bit magic code.
//   Each accepted frame is written to the RX FIFO as one descriptor word
//   followed by its payload words. The first payload word is XGMII word 7.
//   The descriptor is the only word with lane_valid == 0.
//
// Optional build macro: XGMII_RX_STATS_EN adds frame/accept/drop/per-channel
//   counters. Without it those ports and registers do not exist.
//
// Ports
//   xgmii_clk    in   clock
//   sys_rst      in   synchronous active-high reset
//   xgmii_rxc    in   [7:0]  XGMII control, one bit per lane
//   xgmii_rxd    in   [63:0] XGMII data, lane 0 = [7:0]
//   if_v4addr    in   [31:0] local IPv4 address
//   if_macaddr   in   [47:0] local MAC address
//   din          out  [71:0] FIFO word {lane_valid[7:0], data[63:0]}
//   full         in   FIFO full
//   wr_en        out  FIFO write strobe
//   led          out  [7:0]  payload byte 4 of the last accepted frame
//   rx_frames, rx_accepted, rx_dropped  out [31:0]       (stats build only)
//   rx_chan_hits                        out [NUM_PORTS*16-1:0] (stats build only)
//
// state   | meaning
// IDLE    | between frames, waiting for a non-idle word
// HDR     | words 1..6, capturing header fields
// FWD     | frame accepted, payload words forwarded
// DISCARD | rest of the frame ignored until an idle word
module xgmii_udp_rx_filter #(
   parameter int unsigned NUM_PORTS = 2,
   parameter int unsigned PORT_BASE = 3422,
   parameter logic [31:0] MAGIC     = 32'h0
) (
   input  logic        xgmii_clk,
   input  logic        sys_rst,
   input  logic [7:0]  xgmii_rxc,
   input  logic [63:0] xgmii_rxd,
   input  logic [31:0] if_v4addr,
   input  logic [47:0] if_macaddr,
   output logic [71:0] din,
   input  logic        full,
   output logic        wr_en,
   output logic [7:0]  led
`ifdef XGMII_RX_STATS_EN
   ,
   output logic [31:0]              rx_frames,
   output logic [31:0]              rx_accepted,
   output logic [31:0]              rx_dropped,
   output logic [NUM_PORTS*16-1:0]  rx_chan_hits
`endif
);

   typedef enum logic [1:0] {IDLE, HDR, FWD, DISCARD} state_t;

   localparam logic [16:0] PORT_LO  = 17'(PORT_BASE);
   localparam logic [16:0] PORT_HI  = 17'(PORT_BASE + NUM_PORTS);
   localparam logic [7:0]  CHAN_SUB = 8'(PORT_BASE);

   state_t      state_q, state_d;
   logic [10:0] widx_q, widx_d;
   logic        armed_q, armed_d;

   logic [47:0] dmac_q;
   logic [15:0] etype_q;
   logic [7:0]  proto_q;
   logic [31:0] sip_q;
   logic [31:0] dip_q;
   logic [15:0] dport_q;
   logic [15:0] ulen_q;

   logic        wr_d;
   logic [71:0] din_d;
   logic [7:0]  led_d;

   logic        idle_word;
   logic        ctrl_fd, ctrl_fe, ctrl_err;
   logic [31:0] live_magic;
   logic        accept;
   logic [7:0]  chan;

   assign idle_word = (xgmii_rxc == 8'hff);

   always_comb begin
      ctrl_fd = 1'b0;
      ctrl_fe = 1'b0;
      for (int l = 0; l < 8; l++) begin
         if (xgmii_rxc[l] && (xgmii_rxd[l*8 +: 8] == 8'hfd)) ctrl_fd = 1'b1;
         if (xgmii_rxc[l] && (xgmii_rxd[l*8 +: 8] == 8'hfe)) ctrl_fe = 1'b1;
      end
   end

   assign ctrl_err = ctrl_fd | ctrl_fe;

   // Magic sits in word 6 lanes 2..5, first byte most significant.
   assign live_magic = {xgmii_rxd[23:16], xgmii_rxd[31:24],
                        xgmii_rxd[39:32], xgmii_rxd[47:40]};

   assign accept = ((dmac_q == if_macaddr) || (dmac_q == 48'hffff_ffff_ffff)) &&
                   (etype_q == 16'h0800) &&
                   (proto_q == 8'h11) &&
                   (dip_q == if_v4addr) &&
                   ({1'b0, dport_q} >= PORT_LO) &&
                   ({1'b0, dport_q} <  PORT_HI) &&
                   (live_magic == MAGIC);

   // Channel fits in 8 bits, so only the low bytes of the difference matter.
   assign chan = dport_q[7:0] - CHAN_SUB;

   always_comb begin
      state_d = state_q;
      wr_d    = 1'b0;
      din_d   = 72'h0;
      led_d   = led;
      armed_d = armed_q | idle_word;
      if (idle_word)
         widx_d = 11'd0;
      else if (widx_q == 11'd2047)
         widx_d = widx_q;
      else
         widx_d = widx_q + 11'd1;

      case (state_q)
         IDLE: begin
            // Right after reset we may be mid-frame: wait for an idle word.
            if (!idle_word)
               state_d = armed_q ? HDR : DISCARD;
         end
         HDR: begin
            if (idle_word) begin
               state_d = IDLE;
            end else if (widx_q == 11'd6) begin
               if (accept && !full) begin
                  state_d = FWD;
                  wr_d    = 1'b1;
                  din_d   = {8'h00, chan, 8'h00, ulen_q, sip_q};
                  led_d   = xgmii_rxd[55:48];
               end else begin
                  state_d = DISCARD;
               end
            end else if (ctrl_err) begin
               state_d = DISCARD;
            end
         end
         FWD: begin
            if (idle_word) begin
               state_d = IDLE;
            end else if (full) begin
               state_d = DISCARD;
            end else begin
               wr_d  = 1'b1;
               din_d = {~xgmii_rxc, xgmii_rxd};
               if (ctrl_fe) state_d = DISCARD;
            end
         end
         DISCARD: begin
            if (idle_word) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge xgmii_clk) begin
      if (sys_rst) begin
         state_q <= IDLE;
         widx_q  <= 11'd0;
         armed_q <= 1'b0;
         wr_en   <= 1'b0;
         din     <= 72'h0;
         led     <= 8'h0;
         dmac_q  <= 48'h0;
         etype_q <= 16'h0;
         proto_q <= 8'h0;
         sip_q   <= 32'h0;
         dip_q   <= 32'h0;
         dport_q <= 16'h0;
         ulen_q  <= 16'h0;
      end else begin
         state_q <= state_d;
         widx_q  <= widx_d;
         armed_q <= armed_d;
         wr_en   <= wr_d;
         din     <= din_d;
         led     <= led_d;
         if (state_q == HDR && !idle_word) begin
            case (widx_q)
               11'd1: dmac_q <= {xgmii_rxd[7:0],   xgmii_rxd[15:8],  xgmii_rxd[23:16],
                                 xgmii_rxd[31:24], xgmii_rxd[39:32], xgmii_rxd[47:40]};
               11'd2: etype_q <= {xgmii_rxd[39:32], xgmii_rxd[47:40]};
               11'd3: proto_q <= xgmii_rxd[63:56];
               11'd4: begin
                  sip_q         <= {xgmii_rxd[23:16], xgmii_rxd[31:24],
                                    xgmii_rxd[39:32], xgmii_rxd[47:40]};
                  dip_q[31:16]  <= {xgmii_rxd[55:48], xgmii_rxd[63:56]};
               end
               11'd5: begin
                  dip_q[15:0]   <= {xgmii_rxd[7:0],   xgmii_rxd[15:8]};
                  dport_q       <= {xgmii_rxd[39:32], xgmii_rxd[47:40]};
                  ulen_q        <= {xgmii_rxd[55:48], xgmii_rxd[63:56]};
               end
               default: ;
            endcase
         end
      end
   end

`ifdef XGMII_RX_STATS_EN
   logic ev_start, ev_desc, ev_drop;

   assign ev_start = (state_q == IDLE) && !idle_word && armed_q;
   assign ev_desc  = wr_d && (state_q == HDR);
   // Accepted frame losing its descriptor, or losing a payload word in FWD.
   // FWD always moves to DISCARD on full, so this fires once per frame.
   assign ev_drop  = !idle_word && full &&
                     ((state_q == FWD) || ((state_q == HDR) && (widx_q == 11'd6) && accept));

   always_ff @(posedge xgmii_clk) begin
      if (sys_rst) begin
         rx_frames    <= 32'h0;
         rx_accepted  <= 32'h0;
         rx_dropped   <= 32'h0;
         rx_chan_hits <= '0;
      end else begin
         if (ev_start) rx_frames   <= rx_frames + 32'd1;
         if (ev_desc)  rx_accepted <= rx_accepted + 32'd1;
         if (ev_drop)  rx_dropped  <= rx_dropped + 32'd1;
         for (int c = 0; c < int'(NUM_PORTS); c++) begin
            if (ev_desc && (chan == 8'(c)))
               rx_chan_hits[c*16 +: 16] <= rx_chan_hits[c*16 +: 16] + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_xgmii_udp_rx_filter.sv
module tb_xgmii_udp_rx_filter;

   localparam int unsigned NUM_PORTS = 2;
   localparam int unsigned PORT_BASE = 3422;
   localparam logic [31:0] MAGIC     = 32'hC0FFEE01;
   localparam logic [47:0] MY_MAC    = 48'h02_11_22_33_44_55;
   localparam logic [31:0] MY_IP     = 32'hC0A8_0A02;
   localparam logic [63:0] IDLE_D    = 64'h0707_0707_0707_0707;

   logic        xgmii_clk = 1'b0;
   logic        sys_rst   = 1'b1;
   logic [7:0]  xgmii_rxc = 8'hff;
   logic [63:0] xgmii_rxd = IDLE_D;
   logic [31:0] if_v4addr = MY_IP;
   logic [47:0] if_macaddr = MY_MAC;
   logic [71:0] din;
   logic        full = 1'b0;
   logic        wr_en;
   logic [7:0]  led;
`ifdef XGMII_RX_STATS_EN
   logic [31:0]             rx_frames, rx_accepted, rx_dropped;
   logic [NUM_PORTS*16-1:0] rx_chan_hits;
`endif

   xgmii_udp_rx_filter #(.NUM_PORTS(NUM_PORTS), .PORT_BASE(PORT_BASE), .MAGIC(MAGIC)) dut (
      .xgmii_clk  (xgmii_clk),
      .sys_rst    (sys_rst),
      .xgmii_rxc  (xgmii_rxc),
      .xgmii_rxd  (xgmii_rxd),
      .if_v4addr  (if_v4addr),
      .if_macaddr (if_macaddr),
      .din        (din),
      .full       (full),
      .wr_en      (wr_en),
      .led        (led)
`ifdef XGMII_RX_STATS_EN
      ,
      .rx_frames    (rx_frames),
      .rx_accepted  (rx_accepted),
      .rx_dropped   (rx_dropped),
      .rx_chan_hits (rx_chan_hits)
`endif
   );

   always #5 xgmii_clk = ~xgmii_clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   // frame bytes (dst MAC first) and the XGMII words carrying them
   logic [7:0]  fb [0:255];
   int          nb;
   logic [7:0]  w_rxc  [0:31];
   logic [63:0] w_rxd  [0:31];
   logic        w_full [0:31];
   int          nw;

   logic [7:0]  exp_led = 8'h0;
   int          m_frames = 0, m_acc = 0, m_drop = 0;
   int          m_hits [0:NUM_PORTS-1];
   int          last_writes;

   task automatic build(input logic [47:0] dmac, input logic [15:0] et, input logic [7:0] pr,
                        input logic [31:0] dip, input logic [15:0] dp, input logic [31:0] mg,
                        input int plen);
      logic [31:0] sip;
      logic [15:0] tlen, ulen;
      sip  = $urandom;
      tlen = 16'(28 + plen);
      ulen = 16'(8 + plen);
      for (int k = 0; k < 256; k++) fb[k] = 8'($urandom);
      for (int k = 0; k < 6; k++) fb[k] = dmac[47-8*k -: 8];
      fb[12] = et[15:8];   fb[13] = et[7:0];
      fb[14] = 8'h45;      fb[15] = 8'h00;
      fb[16] = tlen[15:8]; fb[17] = tlen[7:0];
      fb[22] = 8'h40;      fb[23] = pr;
      for (int k = 0; k < 4; k++) fb[26+k] = sip[31-8*k -: 8];
      for (int k = 0; k < 4; k++) fb[30+k] = dip[31-8*k -: 8];
      fb[36] = dp[15:8];   fb[37] = dp[7:0];
      fb[38] = ulen[15:8]; fb[39] = ulen[7:0];
      for (int k = 0; k < 4; k++) fb[42+k] = mg[31-8*k -: 8];
      nb = 42 + plen + 4;
      // pack into XGMII words: preamble/SFD, data, then the word holding the terminate
      nw = 2 + nb / 8;
      w_rxc[0] = 8'h01;
      w_rxd[0] = 64'hd555_5555_5555_55fb;
      w_full[0] = 1'b0;
      for (int i = 1; i < nw; i++) begin
         w_full[i] = 1'b0;
         for (int l = 0; l < 8; l++) begin
            int b;
            b = (i - 1) * 8 + l;
            if (b < nb) begin
               w_rxc[i][l] = 1'b0;
               w_rxd[i][l*8 +: 8] = fb[b];
            end else begin
               w_rxc[i][l] = 1'b1;
               w_rxd[i][l*8 +: 8] = (b == nb) ? 8'hfd : 8'h07;
            end
         end
      end
   endtask

   task automatic build_good(input logic [15:0] dp, input int plen);
      build(MY_MAC, 16'h0800, 8'h11, MY_IP, dp, MAGIC, plen);
   endtask

   function automatic logic has_ctl(input int i, input logic [7:0] code);
      has_ctl = 1'b0;
      for (int l = 0; l < 8; l++)
         if (w_rxc[i][l] && w_rxd[i][l*8 +: 8] == code) has_ctl = 1'b1;
   endfunction

   // Send one frame (optionally truncated at word `cut` by an idle word, or
   // with reset pulsed at word `rst_at`), then n_idle idle words.
   task automatic run_frame(input int cut, input int rst_at, input int n_idle);
      logic        ev [0:31];
      logic [71:0] ew [0:31];
      logic [47:0] dmac;
      logic [15:0] dport, ulen;
      logic [31:0] sip, dip, mg;
      logic        acc, hdr_err;
      int          last, ch;
      logic [7:0]  new_led;

      for (int i = 0; i < 32; i++) begin ev[i] = 1'b0; ew[i] = 72'h0; end
      dmac  = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
      sip   = {fb[26], fb[27], fb[28], fb[29]};
      dip   = {fb[30], fb[31], fb[32], fb[33]};
      dport = {fb[36], fb[37]};
      ulen  = {fb[38], fb[39]};
      mg    = {fb[42], fb[43], fb[44], fb[45]};
      hdr_err = 1'b0;
      for (int i = 1; i <= 5; i++)
         if (has_ctl(i, 8'hfd) || has_ctl(i, 8'hfe)) hdr_err = 1'b1;
      acc = (dmac == MY_MAC || dmac == 48'hffff_ffff_ffff) &&
            ({fb[12], fb[13]} == 16'h0800) && (fb[23] == 8'h11) && (dip == MY_IP) &&
            (int'(dport) >= int'(PORT_BASE)) && (int'(dport) < int'(PORT_BASE + NUM_PORTS)) &&
            (mg == MAGIC) && !hdr_err &&
            (cut < 0 || cut > 6) && (rst_at < 0 || rst_at > 6);
      ch = int'(dport) - int'(PORT_BASE);
      new_led = fb[46];
      m_frames++;
      if (acc) begin
         if (w_full[6]) m_drop++;
         else begin
            ev[6] = 1'b1;
            ew[6] = {8'h00, 8'(ch), 8'h00, ulen, sip};
            m_acc++;
            m_hits[ch]++;
            for (int i = 7; i < nw; i++) begin
               if (i == cut || (rst_at >= 0 && i >= rst_at)) break;
               if (w_rxc[i] == 8'hff) break;
               if (w_full[i]) begin m_drop++; break; end
               ev[i] = 1'b1;
               ew[i] = {~w_rxc[i], w_rxd[i]};
               if (has_ctl(i, 8'hfe)) break;
            end
         end
      end
      if (rst_at >= 0) begin
         m_frames = 0; m_acc = 0; m_drop = 0;
         for (int c = 0; c < int'(NUM_PORTS); c++) m_hits[c] = 0;
      end

      last = (cut >= 0) ? cut : nw - 1;
      last_writes = 0;
      for (int i = 0; i <= last; i++) begin
         if (i == cut) begin
            xgmii_rxc = 8'hff; xgmii_rxd = IDLE_D;
         end else begin
            xgmii_rxc = w_rxc[i]; xgmii_rxd = w_rxd[i];
         end
         full    = w_full[i];
         sys_rst = (i == rst_at);
         @(posedge xgmii_clk);
         #1;
         sys_rst = 1'b0;
         if (wr_en) last_writes++;
         if (ev[i] && i == 6) exp_led = new_led;
         if (i == rst_at) begin
            exp_led = 8'h0;
            chk("led_after_rst", {64'h0, led}, 72'h0);
         end
         chk($sformatf("wr_en_w%0d", i), {71'h0, wr_en}, {71'h0, ev[i]});
         if (ev[i]) chk($sformatf("din_w%0d", i), din, ew[i]);
      end
      for (int k = 0; k < n_idle; k++) begin
         xgmii_rxc = 8'hff; xgmii_rxd = IDLE_D; full = 1'b0;
         @(posedge xgmii_clk);
         #1;
         chk("wr_en_idle", {71'h0, wr_en}, 72'h0);
      end
      full = 1'b0;
      chk("led", {64'h0, led}, {64'h0, exp_led});
   endtask

   initial begin
      for (int c = 0; c < int'(NUM_PORTS); c++) m_hits[c] = 0;
      sys_rst = 1'b1;
      repeat (3) @(posedge xgmii_clk);
      #1;
      chk("rst_wr_en", {71'h0, wr_en}, 72'h0);
      chk("rst_din", din, 72'h0);
      chk("rst_led", {64'h0, led}, 72'h0);
      sys_rst = 1'b0;
      repeat (2) @(posedge xgmii_clk);
      #1;

      // matching frame, 64-byte payload: descriptor + 7 payload + terminate word
      build_good(16'd3422, 64);
      run_frame(-1, -1, 2);
      chk("writes_64B", 72'(last_writes), 72'd9);
      chk("led_is_byte4", {64'h0, led}, {64'h0, fb[46]});

      build_good(16'd3423, 40); run_frame(-1, -1, 2);
      build_good(16'd3424, 40); run_frame(-1, -1, 2);
      chk("writes_3424", 72'(last_writes), 72'd0);
      build_good(16'd3421, 40); run_frame(-1, -1, 2);
      chk("writes_3421", 72'(last_writes), 72'd0);

      build(48'hffff_ffff_ffff, 16'h0800, 8'h11, MY_IP, 16'd3422, MAGIC, 32); run_frame(-1, -1, 2);
      build(MY_MAC, 16'h0800, 8'h11, MY_IP ^ 32'h1, 16'd3422, MAGIC, 32);     run_frame(-1, -1, 2);
      build(MY_MAC, 16'h86dd, 8'h11, MY_IP, 16'd3422, MAGIC, 32);             run_frame(-1, -1, 2);
      build(MY_MAC, 16'h0800, 8'h06, MY_IP, 16'd3422, MAGIC, 32);             run_frame(-1, -1, 2);
      build(MY_MAC, 16'h0800, 8'h11, MY_IP, 16'd3422, MAGIC ^ 32'h100, 32);   run_frame(-1, -1, 2);
      chk("writes_badmagic", 72'(last_writes), 72'd0);
      build_good(16'd3422, 32); run_frame(-1, -1, 2);

      // FIFO full at the descriptor decision, then for one mid-payload word
      build_good(16'd3422, 64); w_full[6] = 1'b1; run_frame(-1, -1, 2);
      chk("writes_full_desc", 72'(last_writes), 72'd0);
      build_good(16'd3423, 64); w_full[9] = 1'b1; run_frame(-1, -1, 2);
      chk("writes_full_mid", 72'(last_writes), 72'd3);

      // truncated at w4, good frame back to back
      build_good(16'd3422, 48); run_frame(4, -1, 0);
      build_good(16'd3423, 48); run_frame(-1, -1, 2);

      // reset mid-payload, then a normal frame
      build_good(16'd3422, 64); run_frame(-1, 9, 2);
      build_good(16'd3423, 24); run_frame(-1, -1, 2);

      // randomized frames
      for (int f = 0; f < 60; f++) begin
         logic [47:0] dm;
         logic [15:0] et, dp;
         logic [7:0]  pr;
         logic [31:0] ip, mg;
         int          kind, cut, n_idle;
         dm = MY_MAC; et = 16'h0800; pr = 8'h11; ip = MY_IP; mg = MAGIC;
         dp = 16'(PORT_BASE + $urandom_range(0, NUM_PORTS - 1));
         kind = $urandom_range(0, 9);
         case (kind)
            1: dm = 48'hffff_ffff_ffff;
            2: dm = MY_MAC ^ (48'h1 << $urandom_range(0, 47));
            3: ip = MY_IP ^ (32'h1 << $urandom_range(0, 31));
            4: et = 16'h86dd;
            5: pr = 8'h06;
            6: mg = MAGIC ^ (32'h1 << $urandom_range(0, 31));
            7: dp = 16'(int'(PORT_BASE) + int'($urandom_range(0, 5)) - 2);
            default: ;
         endcase
         build(dm, et, pr, ip, dp, mg, $urandom_range(16, 80));
         if ($urandom_range(0, 7) == 0) w_full[6] = 1'b1;
         for (int i = 7; i < nw; i++)
            if ($urandom_range(0, 15) == 0) w_full[i] = 1'b1;
         if ($urandom_range(0, 7) == 0) begin
            int wi, ln;
            wi = $urandom_range(7, nw - 2);
            ln = $urandom_range(0, 7);
            w_rxc[wi][ln] = 1'b1;
            w_rxd[wi][ln*8 +: 8] = 8'hfe;
         end
         if ($urandom_range(0, 15) == 0) begin
            int wi, ln;
            wi = $urandom_range(1, 5);
            ln = $urandom_range(0, 7);
            w_rxc[wi][ln] = 1'b1;
            w_rxd[wi][ln*8 +: 8] = ($urandom_range(0, 1) == 0) ? 8'hfe : 8'hfd;
         end
         cut = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, nw - 1)) : -1;
         n_idle = (cut >= 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
         run_frame(cut, -1, n_idle);
      end

`ifdef XGMII_RX_STATS_EN
      chk("rx_frames", 72'(rx_frames), 72'(m_frames));
      chk("rx_accepted", 72'(rx_accepted), 72'(m_acc));
      chk("rx_dropped", 72'(rx_dropped), 72'(m_drop));
      for (int c = 0; c < int'(NUM_PORTS); c++)
         chk($sformatf("rx_chan_hits%0d", c), 72'(rx_chan_hits[c*16 +: 16]), 72'(m_hits[c] % 65536));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
